// File: rtl/hc_sr04_emulator.sv
// HC-SR04 ultrasonic ranging sensor emulator: trig pulse qualification, burst delay, distance-scaled echo and holdoff.
// Optional macro HCSR04_EMU_RANGE_EN: distances beyond MAX_CM produce a TIMEOUT_US echo instead.
module hc_sr04_emulator #(
    parameter int unsigned CLKS_PER_US    = 125,
    parameter int unsigned MIN_TRIG_US    = 10,
    parameter int unsigned BURST_DELAY_US = 200,
    parameter int unsigned US_PER_CM      = 58,
    parameter int unsigned HOLDOFF_US     = 10000,
    parameter int unsigned MAX_CM         = 400,
    parameter int unsigned TIMEOUT_US     = 38000
) (
    input  logic        clk_125mhz,
    input  logic        reset,
    input  logic        trig,
    input  logic [15:0] distance_cm,
    output logic        echo,
    output logic        busy,
    output logic        trig_rejected,
    output logic        echo_done
);

    localparam logic [31:0] MIN_TRIG_CYC    = 32'(MIN_TRIG_US * CLKS_PER_US);
    localparam logic [31:0] BURST_CYC       = 32'(BURST_DELAY_US * CLKS_PER_US);
    localparam logic [31:0] ECHO_CYC_PER_CM = 32'(US_PER_CM * CLKS_PER_US);
    localparam logic [31:0] HOLDOFF_CYC     = 32'(HOLDOFF_US * CLKS_PER_US);
`ifdef HCSR04_EMU_RANGE_EN
    localparam logic [31:0] MAX_CM_W        = 32'(MAX_CM);
    localparam logic [31:0] TIMEOUT_CYC     = 32'(TIMEOUT_US * CLKS_PER_US);
`endif

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [15:0] dist_q, dist_nx;
    logic        trig_meta, trig_s;
    logic        echo_nx, busy_nx, rej_nx, done_nx;
    logic [31:0] w_cm;
    logic [31:0] echo_width;

    // Zero distance is reported as the 1 cm minimum
    always_comb begin
        w_cm = (dist_q == '0) ? 32'd1 : {16'd0, dist_q};
        echo_width = w_cm * ECHO_CYC_PER_CM;
`ifdef HCSR04_EMU_RANGE_EN
        if ({16'd0, dist_q} > MAX_CM_W) begin
            echo_width = TIMEOUT_CYC;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dist_nx  = dist_q;
        echo_nx  = 1'b0;
        busy_nx  = 1'b0;
        rej_nx   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (trig_s) begin
                    state_nx = TRIG_HI;
                    cnt_nx   = 32'd1;
                end
            end
            TRIG_HI: begin
                if (trig_s) begin
                    if (cnt != '1) begin
                        cnt_nx = cnt + 32'd1;
                    end
                end else if (cnt >= MIN_TRIG_CYC) begin
                    state_nx = BURST;
                    cnt_nx   = 32'd1;
                    dist_nx  = distance_cm;
                    busy_nx  = 1'b1;
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    rej_nx   = 1'b1;
                end
            end
            BURST: begin
                busy_nx = 1'b1;
                if (cnt >= BURST_CYC) begin
                    state_nx = ECHO;
                    cnt_nx   = 32'd1;
                    echo_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end
            ECHO: begin
                busy_nx = 1'b1;
                echo_nx = 1'b1;
                if (cnt >= echo_width) begin
                    state_nx = HOLDOFF;
                    cnt_nx   = 32'd1;
                    echo_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end
            HOLDOFF: begin
                busy_nx = 1'b1;
                if (cnt >= HOLDOFF_CYC) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            trig_meta     <= 1'b0;
            trig_s        <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            dist_q        <= '0;
            echo          <= 1'b0;
            busy          <= 1'b0;
            trig_rejected <= 1'b0;
            echo_done     <= 1'b0;
        end else begin
            trig_meta     <= trig;
            trig_s        <= trig_meta;
            state         <= state_nx;
            cnt           <= cnt_nx;
            dist_q        <= dist_nx;
            echo          <= echo_nx;
            busy          <= busy_nx;
            trig_rejected <= rej_nx;
            echo_done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_hc_sr04_emulator.sv
// Self-checking bench for hc_sr04_emulator: directed and random trig pulses against a timeline model.
module tb_hc_sr04_emulator;

    localparam int CPU  = 2;
    localparam int MINT = 3;
    localparam int BD   = 4;
    localparam int UPC  = 3;
    localparam int HOLD = 5;
    localparam int MAXC = 20;
    localparam int TMO  = 40;
    localparam int M    = MINT * CPU;
    localparam int D    = BD * CPU;
    localparam int H    = HOLD * CPU;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] distance_cm = '0;
    logic        echo, busy, trig_rejected, echo_done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    // expected output windows, in cycles counted from the first clock edge
    int e_rise = -1, e_fall = -1, b_start = -1, b_end = -1;
    int done_cyc = -1, rej_cyc = -1, idle_from = 0;

    hc_sr04_emulator #(
        .CLKS_PER_US   (CPU),
        .MIN_TRIG_US   (MINT),
        .BURST_DELAY_US(BD),
        .US_PER_CM     (UPC),
        .HOLDOFF_US    (HOLD),
        .MAX_CM        (MAXC),
        .TIMEOUT_US    (TMO)
    ) dut (
        .clk_125mhz   (clk),
        .reset        (reset),
        .trig         (trig),
        .distance_cm  (distance_cm),
        .echo         (echo),
        .busy         (busy),
        .trig_rejected(trig_rejected),
        .echo_done    (echo_done)
    );

    always #5 clk = ~clk;

    function automatic int width_of(int d);
`ifdef HCSR04_EMU_RANGE_EN
        if (d > MAXC) return TMO * CPU;
`endif
        return ((d == 0) ? 1 : d) * UPC * CPU;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("echo", echo, logic'(cyc >= e_rise && cyc < e_fall));
        check("busy", busy, logic'(cyc >= b_start && cyc < b_end));
        check("echo_done", echo_done, logic'(cyc == done_cyc));
        check("trig_rejected", trig_rejected, logic'(cyc == rej_cyc));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Trig seen by the FSM 3 edges after the drive; only edges while idle count toward the width
    task automatic trig_pulse(int n, int d);
        int r, k, e0, nn, f;
        distance_cm = 16'(d);
        trig = 1'b1;
        r = cyc;
        ticks(n);
        trig = 1'b0;
        k = cyc;
        e0 = (r + 3 > idle_from) ? r + 3 : idle_from;
        if (e0 > k + 2) return;
        nn = k + 3 - e0;
        if (nn < M) begin
            rej_cyc   = k + 3;
            idle_from = k + 4;
        end else begin
            f         = k + 3;
            b_start   = f;
            e_rise    = f + D;
            e_fall    = e_rise + width_of(d);
            done_cyc  = e_fall;
            b_end     = e_fall + H;
            idle_from = b_end + 1;
        end
    endtask

    task automatic wait_idle();
        while (cyc < idle_from) tick();
        ticks(2);
    endtask

    task automatic do_reset(int n);
        int c;
        c = cyc;
        reset = 1'b1;
        if (e_fall > c + 1) e_fall = c + 1;
        if (b_end > c + 1) b_end = c + 1;
        if (done_cyc > c) done_cyc = -1;
        if (rej_cyc > c) rej_cyc = -1;
        ticks(n);
        reset = 1'b0;
        idle_from = cyc + 1;
    endtask

    initial begin
        do_reset(4);
        ticks(3);

        trig_pulse(8, 25);   wait_idle();
        trig_pulse(4, 25);   wait_idle();
        trig_pulse(M, 7);    wait_idle();
        trig_pulse(M - 1, 7); wait_idle();
        trig_pulse(8, 0);    wait_idle();
        trig_pulse(8, 500);  wait_idle();

        // retrigger and distance change during echo are ignored
        trig_pulse(8, 25);
        while (cyc < e_rise + 5) tick();
        distance_cm = 16'd100;
        ticks(3);
        trig_pulse(8, 100);
        distance_cm = 16'd3;
        wait_idle();

        // trig during burst is ignored
        trig_pulse(7, 9);
        ticks(2);
        trig_pulse(3, 9);
        wait_idle();

        // reset mid-echo, then normal service
        trig_pulse(8, 25);
        while (cyc < e_rise + 10) tick();
        do_reset(2);
        ticks(3);
        trig_pulse(8, 12);
        wait_idle();

        // trig held across holdoff exit: measured from idle only
        trig_pulse(8, 10);
        while (cyc < idle_from - 5) tick();
        trig_pulse(7, 10);
        wait_idle();
        trig_pulse(8, 10);
        while (cyc < idle_from - 5) tick();
        trig_pulse(9, 10);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            trig_pulse(int'($urandom_range(1, 12)), int'($urandom_range(0, 30)));
            if ($urandom_range(0, 1) == 1) begin
                ticks(D + 2);
                trig_pulse(int'($urandom_range(1, 10)), int'($urandom_range(0, 30)));
            end
            ticks(int'($urandom_range(0, 3)));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
